// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: data widths, the RISC-V memory
// funct3 encodings, FSM states, error codes, the latched request payload and
// small helpers for error classification and store lane packing.
package load_store_unit_pkg;

  localparam int unsigned REGISTER_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BYTES_PER_WORD = REGISTER_WIDTH / BYTE_WIDTH;
  localparam int unsigned HALF_WIDTH     = 2 * BYTE_WIDTH;
  localparam int unsigned FUNCT3_WIDTH   = 3;
  localparam int unsigned REG_IDX_WIDTH  = 5;
  localparam int unsigned ERROR_WIDTH    = 2;

  // Loads and stores share the low two bits for access size; bit 2 selects
  // zero extension for loads and is never legal for stores.
  typedef enum logic [FUNCT3_WIDTH-1:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_funct3_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [ERROR_WIDTH-1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_ILLEGAL    = 2'd2
  } lsu_error_t;

  // Request fields that must survive past the accept edge.
  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] addr;
    logic [FUNCT3_WIDTH-1:0]   funct3;
    logic                      is_store;
    logic [REG_IDX_WIDTH-1:0]  rd;
  } lsu_req_t;

  // Illegal encodings win over misalignment.
  function automatic lsu_error_t lsu_check(input logic                    is_store,
                                           input logic [FUNCT3_WIDTH-1:0] funct3,
                                           input logic [1:0]              addr_lo);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = (funct3 >= 3'b011);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (illegal) begin
      lsu_check = ERR_ILLEGAL;
    end else if (misaligned) begin
      lsu_check = ERR_MISALIGNED;
    end else begin
      lsu_check = ERR_NONE;
    end
  endfunction

  function automatic logic [BYTES_PER_WORD-1:0] store_byte_enable(input logic [1:0] size);
    case (size)
      2'b00:   store_byte_enable = 4'b0001;
      2'b01:   store_byte_enable = 4'b0011;
      default: store_byte_enable = 4'b1111;
    endcase
  endfunction

  // Store data sits in the low lanes; unused upper lanes are forced to zero.
  function automatic logic [REGISTER_WIDTH-1:0] store_lane_data(input logic [1:0]                size,
                                                                input logic [REGISTER_WIDTH-1:0] data);
    case (size)
      2'b00:   store_lane_data = {(REGISTER_WIDTH-BYTE_WIDTH)'(0), data[BYTE_WIDTH-1:0]};
      2'b01:   store_lane_data = {(REGISTER_WIDTH-HALF_WIDTH)'(0), data[HALF_WIDTH-1:0]};
      default: store_lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extension.
//   funct3_i : load funct3 (LB/LH/LW/LBU/LHU)
//   raw_i    : raw SRAM word, lane i = byte at address+i
//   data_o   : sign/zero-extended result (raw word for LW or unknown codes)
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [FUNCT3_WIDTH-1:0]   funct3_i,
  input  logic [REGISTER_WIDTH-1:0] raw_i,
  output logic [REGISTER_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (mem_funct3_t'(funct3_i))
      F3_B:    data_o = {{(REGISTER_WIDTH-BYTE_WIDTH){raw_i[BYTE_WIDTH-1]}}, raw_i[BYTE_WIDTH-1:0]};
      F3_H:    data_o = {{(REGISTER_WIDTH-HALF_WIDTH){raw_i[HALF_WIDTH-1]}}, raw_i[HALF_WIDTH-1:0]};
      F3_BU:   data_o = {(REGISTER_WIDTH-BYTE_WIDTH)'(0), raw_i[BYTE_WIDTH-1:0]};
      F3_HU:   data_o = {(REGISTER_WIDTH-HALF_WIDTH)'(0), raw_i[HALF_WIDTH-1:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and writeback.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   req_*                    : request from execute (valid/ready handshake)
//   mem_*                    : SRAM data port (combinational read, one-cycle write)
//   resp_*                   : response to writeback (valid/ready handshake)
// Flow: IDLE accepts, ACCESS drives the SRAM for one cycle, RESP holds the
// result until taken. Faulting requests jump straight to RESP.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [FUNCT3_WIDTH-1:0]   req_funct3,
  input  logic [REGISTER_WIDTH-1:0] req_base,
  input  logic [REGISTER_WIDTH-1:0] req_offset,
  input  logic [REGISTER_WIDTH-1:0] req_store_data,
  input  logic [REG_IDX_WIDTH-1:0]  req_rd,
  output logic                      mem_write_en,
  output logic [REGISTER_WIDTH-1:0] mem_address,
  output logic [REGISTER_WIDTH-1:0] mem_write_data,
  output logic [BYTES_PER_WORD-1:0] mem_byte_enable,
  input  logic [REGISTER_WIDTH-1:0] mem_read_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [REG_IDX_WIDTH-1:0]  resp_rd,
  output logic [REGISTER_WIDTH-1:0] resp_data,
  output logic [ERROR_WIDTH-1:0]    resp_error,
  output logic [REGISTER_WIDTH-1:0] resp_addr
);

  lsu_state_t                state_q, state_d;
  lsu_req_t                  req_q, req_d;
  logic                      req_ready_q, req_ready_d;
  logic                      mem_we_q, mem_we_d;
  logic [REGISTER_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REGISTER_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BYTES_PER_WORD-1:0] mem_be_q, mem_be_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [REG_IDX_WIDTH-1:0]  resp_rd_q, resp_rd_d;
  logic [REGISTER_WIDTH-1:0] resp_data_q, resp_data_d;
  lsu_error_t                resp_error_q, resp_error_d;
  logic [REGISTER_WIDTH-1:0] resp_addr_q, resp_addr_d;

  logic [REGISTER_WIDTH-1:0] eff_addr_c;
  lsu_error_t                accept_err_c;
  logic [REGISTER_WIDTH-1:0] load_ext_c;

  // Effective address wraps modulo 2^32 by construction.
  assign eff_addr_c   = req_base + req_offset;
  assign accept_err_c = lsu_check(req_is_store, req_funct3, eff_addr_c[1:0]);

  // Extension runs on the latched funct3 against the live SRAM read in ACCESS.
  lsu_load_extend u_load_extend (
    .funct3_i (req_q.funct3),
    .raw_i    (mem_read_data),
    .data_o   (load_ext_c)
  );

  // Next-state and next-output logic; write strobes default low so they can
  // only be high for the single cycle spent in ACCESS.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_we_d     = 1'b0;
    mem_be_d     = '0;
    mem_wdata_d  = '0;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    resp_addr_d  = resp_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d.addr     = eff_addr_c;
          req_d.funct3   = req_funct3;
          req_d.is_store = req_is_store;
          req_d.rd       = req_rd;
          if (accept_err_c != ERR_NONE) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = accept_err_c;
            resp_rd_d    = '0;
            resp_data_d  = '0;
            resp_addr_d  = eff_addr_c;
          end else begin
            state_d    = ST_ACCESS;
            mem_addr_d = eff_addr_c;
            if (req_is_store) begin
              mem_we_d    = 1'b1;
              mem_be_d    = store_byte_enable(req_funct3[1:0]);
              mem_wdata_d = store_lane_data(req_funct3[1:0], req_store_data);
            end
          end
        end
      end

      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_error_d = ERR_NONE;
        resp_addr_d  = req_q.addr;
        resp_rd_d    = req_q.is_store ? '0 : req_q.rd;
        resp_data_d  = req_q.is_store ? '0 : load_ext_c;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset kills any in-flight access at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_error_q <= ERR_NONE;
      resp_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      resp_addr_q  <= resp_addr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_write_en    = mem_we_q;
  assign mem_address     = mem_addr_q;
  assign mem_write_data  = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rd         = resp_rd_q;
  assign resp_data       = resp_data_q;
  assign resp_error      = resp_error_q;
  assign resp_addr       = resp_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// random loads/stores checked against a byte-array memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_error;
  logic [31:0] resp_addr;

  int checks = 0;
  int fails  = 0;

  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_base        (req_base),
    .req_offset      (req_offset),
    .req_store_data  (req_store_data),
    .req_rd          (req_rd),
    .mem_write_en    (mem_write_en),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_byte_enable (mem_byte_enable),
    .mem_read_data   (mem_read_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rd         (resp_rd),
    .resp_data       (resp_data),
    .resp_error      (resp_error),
    .resp_addr       (resp_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 256-byte SRAM, address taken modulo 256, byte-enable writes on the edge.
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 8'(i * 37 + 11);
    forever begin
      @(posedge clk);
      if (mem_write_en) begin
        for (int i = 0; i < 4; i++)
          if (mem_byte_enable[i]) sram[8'(mem_address + 32'(i))] = mem_write_data[8*i +: 8];
      end
    end
  end

  assign mem_read_data = {sram[8'(mem_address + 32'd3)], sram[8'(mem_address + 32'd2)],
                          sram[8'(mem_address + 32'd1)], sram[8'(mem_address)]};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Error classification from the ISA rules: bad encodings first, then
  // natural alignment of the access size.
  function automatic logic [1:0] exp_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 2'd2;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int          n;
    logic [31:0] v;
    n = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (f3[2] == 1'b0 && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic scramble_req();
    req_is_store   = 1'($urandom);
    req_funct3     = 3'($urandom);
    req_base       = $urandom;
    req_offset     = $urandom;
    req_store_data = $urandom;
    req_rd         = 5'($urandom);
  endtask

  // One complete transaction with all protocol and data checks.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] data,
                       input logic [4:0] rd, input int hold);
    logic [31:0] ea, ev, ewd;
    logic [3:0]  ebe;
    logic [1:0]  ee;
    logic [4:0]  erd;
    int          n;
    ea  = base + off;
    ee  = exp_err(st, f3, ea);
    n   = 1 << f3[1:0];
    ebe = 4'((1 << n) - 1);
    ewd = (n == 4) ? data : (data & ((32'd1 << (8 * n)) - 1));
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_store_data = data; req_rd = rd;
    resp_ready = (hold == 0);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    scramble_req();
    if (ee != 2'd0) begin
      req_valid = 1'b0;
      check("err_resp_valid_n1", 32'(resp_valid), 32'd1);
      check("err_code", 32'(resp_error), 32'(ee));
      check("err_addr", resp_addr, ea);
      check("err_rd", 32'(resp_rd), 32'd0);
      check("err_data", resp_data, 32'd0);
      check("err_no_write", 32'(mem_write_en), 32'd0);
      ev = 0; erd = 0;
    end else begin
      req_valid = 1'b1;
      check("acc_resp_valid_n1", 32'(resp_valid), 32'd0);
      check("acc_req_ready", 32'(req_ready), 32'd0);
      check("acc_addr", mem_address, ea);
      check("acc_we", 32'(mem_write_en), 32'(st));
      check("acc_be", 32'(mem_byte_enable), st ? 32'(ebe) : 32'd0);
      if (st) begin
        check("acc_wdata", mem_write_data, ewd);
        for (int i = 0; i < n; i++) ref_mem[8'(ea + 32'(i))] = data[8*i +: 8];
        ev = 0; erd = 0;
      end else begin
        ev = exp_load(f3, ea); erd = rd;
      end
      step();
      req_valid = 1'b0;
      check("resp_valid_n2", 32'(resp_valid), 32'd1);
      check("resp_error", 32'(resp_error), 32'd0);
      check("resp_addr", resp_addr, ea);
      check("resp_rd", 32'(resp_rd), 32'(erd));
      check("resp_data", resp_data, ev);
      check("resp_we_low", 32'(mem_write_en), 32'd0);
      check("resp_be_low", 32'(mem_byte_enable), 32'd0);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      scramble_req();
      step();
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, ev);
      check("hold_addr", resp_addr, ea);
      check("hold_err", 32'(resp_error), 32'(ee));
      check("hold_rd", 32'(resp_rd), 32'(erd));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_no_write", 32'(mem_write_en), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    check("done_valid_low", 32'(resp_valid), 32'd0);
    check("done_req_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] base, off, data;
    logic [2:0]  f3;
    bit          st;
    int          n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    rst = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = 0; req_offset = 0; req_store_data = 0; req_rd = 5'd0; resp_ready = 1'b0;

    // Reset values
    step(); step(); step();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", 32'(resp_rd), 32'd0);
    check("rst_resp_addr", resp_addr, 32'd0);
    check("rst_we", 32'(mem_write_en), 32'd0);
    check("rst_be", 32'(mem_byte_enable), 32'd0);
    check("rst_maddr", mem_address, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    #3 rst = 1'b1;
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // SW 0x100+4, then SB 0x80 at 0x105 for the sign-extension loads
    do_op(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd7, 0);
    do_op(1'b1, 3'b000, 32'h105, 32'h0, 32'h12345680, 5'd3, 0);
    do_op(1'b0, 3'b000, 32'h105, 32'h0, 32'h0, 5'd9, 0);
    check("lb_const", resp_data, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h105, 32'h0, 32'h0, 5'd10, 0);
    check("lbu_const", resp_data, 32'h00000080);
    // Misaligned word and illegal-over-misaligned
    do_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 5'd4, 0);
    check("mis_const", 32'(resp_error), 32'd1);
    do_op(1'b0, 3'b011, 32'h101, 32'h0, 32'h0, 5'd4, 0);
    check("ill_const", 32'(resp_error), 32'd2);
    do_op(1'b1, 3'b011, 32'h100, 32'h0, 32'h55, 5'd4, 1);
    // Back-pressure for five cycles, and wrap-around of the address sum
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5'd31, 5);
    do_op(1'b1, 3'b001, 32'hFFFF_FFF0, 32'h30, 32'hCAFE_1234, 5'd1, 0);
    do_op(1'b0, 3'b101, 32'h20, 32'h0, 32'h0, 5'd2, 0);

    // Reset in the middle of a store ACCESS drops it without an edge
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h40; req_offset = 0; req_store_data = 32'hA5A5A5A5; req_rd = 5'd1;
    step();
    req_valid = 1'b0;
    check("rstacc_we_before", 32'(mem_write_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstacc_we_async", 32'(mem_write_en), 32'd0);
    check("rstacc_be_async", 32'(mem_byte_enable), 32'd0);
    check("rstacc_resp_valid", 32'(resp_valid), 32'd0);
    #2 rst = 1'b1;
    step();
    check("rstacc_req_ready", 32'(req_ready), 32'd1);
    check("rstacc_no_resp", 32'(resp_valid), 32'd0);
    step();
    check("rstacc_no_resp2", 32'(resp_valid), 32'd0);
    do_op(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd6, 0);

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else begin
        f3 = 3'($urandom);
      end
      base = $urandom;
      off  = 32'($urandom_range(0, 127)) - 32'd64;
      data = $urandom;
      n    = 1 << f3[1:0];
      if ($urandom_range(0, 9) < 7) base = base - ((base + off) % n);
      do_op(st, f3, base, off, data, 5'($urandom), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; rst asserted (low) forces reset state immediately, independent of clk.
REQ-002 SHALL take no module parameters; widths come from the shared package: REGISTER_WIDTH=32, BYTE_WIDTH=8.
REQ-003 SHALL expose the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-low reset
- req_valid  in  1  execute stage offers a memory op
- req_ready  out  1  LSU can accept a request this cycle
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_store_data  in  32  rs2 value
- req_rd  in  5  load destination register
- mem_write_en  out  1  to SRAM data-port write enable
- mem_address  out  32  to SRAM data-port byte address
- mem_write_data  out  32  to SRAM data-port write data, lane i = byte at address+i
- mem_byte_enable  out  4  to SRAM data-port byte enables, bit i = byte at address+i
- mem_read_data  in  32  from SRAM combinational read, lane i = byte at address+i
- resp_valid  out  1  response to writeback stage
- resp_ready  in  1  writeback accepts response
- resp_rd  out  5  destination register, 0 for stores and errors
- resp_data  out  32  extended load data, 0 for stores and errors
- resp_error  out  2  0=none, 1=misaligned, 2=illegal funct3
- resp_addr  out  32  effective address of the op

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = (state==IDLE).
REQ-005 SHALL accept on req_valid&&req_ready and register effective address = req_base+req_offset (mod 2^32; wrap, no overflow flag), funct3, is_store, rd, store data.
REQ-006 SHALL detect errors at accept: illegal funct3 (load 011/110/111, store >=011) -> error 2; else halfword with addr[0]!=0 or word with addr[1:0]!=0 -> error 1; illegal takes priority.
REQ-007 SHALL go from IDLE to RESP directly on error, skipping ACCESS; no SRAM write occurs.
REQ-008 In ACCESS, SHALL drive mem_address with the registered address; store: mem_write_en=1 for exactly that cycle, byte enables SB=0001, SH=0011, SW=1111, data in low lanes, upper lanes 0.
REQ-009 mem_write_en SHALL be 0 in every state but ACCESS-with-store; mem_byte_enable SHALL be 0000 when mem_write_en=0.
REQ-010 In ACCESS for loads, SHALL capture mem_read_data into resp_data: LB/LH sign-extend lane0/lanes1:0, LBU/LHU zero-extend, LW unchanged.
REQ-011 In RESP, resp_valid=1 and all resp_* SHALL hold stable until resp_ready; on the accepting edge go to IDLE.
REQ-012 Latency: request accepted at edge N -> resp_valid from N+2 (error: N+1); max throughput one op per 3 cycles.
REQ-013 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-014 Reset SHALL force IDLE, resp_valid=0, resp_error=0, resp_data=0, resp_rd=0, resp_addr=0, mem_write_en=0, mem_byte_enable=0, mem_address=0, mem_write_data=0; req_ready=1 after release.
REQ-015 Reset during ACCESS SHALL deassert mem_write_en immediately; the in-flight op is dropped with no response.

Structure
REQ-016 Shared package SHALL hold REGISTER_WIDTH, BYTE_WIDTH, mem_funct3_t enum, lsu_state_t, lsu_error_t.
REQ-017 Load extension SHALL be a combinational sub-module lsu_load_extend (funct3, raw 32b -> extended 32b).

Verification
REQ-018 SW base=0x100 off=0x4 data=0xDEADBEEF -> ACCESS cycle: addr 0x104, we=1, be=1111, wdata=0xDEADBEEF; resp error 0, rd 0.
REQ-019 LB at 0x105 with mem lane0=0x80 -> resp_data=0xFFFFFF80; LBU same -> 0x00000080; resp_valid 2 cycles after accept.
REQ-020 LW base=0x102 off=0 -> resp_error=1, resp_addr=0x102, resp_valid 1 cycle after accept, mem_write_en never asserted.
REQ-021 Load funct3=011 -> resp_error=2 even when address misaligned.
REQ-022 Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0; new req_valid ignored until return to IDLE.
REQ-023 Assert rst during store ACCESS -> mem_write_en falls without clock edge; after release req_ready=1, resp_valid=0.
